// File: rtl/idct_zigzag_block_feeder_if.sv
// ---------------------------------------------------------------------------
// idct_zigzag_block_feeder_if
// Minimal AXI-stream bundle used on both sides of the zig-zag block feeder.
//   W      : tdata width in bits
//   tdata  : payload
//   tvalid : payload valid (driven by master)
//   tready : sink can accept (driven by slave)
//   tlast  : final beat of a packet/block
// Modports:
//   master : drives tdata/tvalid/tlast, observes tready
//   slave  : observes tdata/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface idct_zigzag_block_feeder_if #(
    parameter int W = 12
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/idct_zigzag_block_feeder.sv
// ---------------------------------------------------------------------------
// idct_zigzag_block_feeder
// Accepts quantised coefficients one per beat in zig-zag order (with optional
// early end-of-block via tlast), de-scans them into natural 8x8 order in a
// ping-pong pair of banks, zero-fills unsent positions and emits each block as
// 8 row beats of 8 packed coefficients.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; discards all buffered blocks
//   s     : slave stream, one WIN-bit coefficient per beat, zig-zag order
//   m     : master stream, one 8*WIN-bit row per beat, lane j = column j,
//           tlast on row 7 of each block
// ---------------------------------------------------------------------------
module idct_zigzag_block_feeder #(
    parameter int WIN = 12
) (
    input  logic                         clock,
    input  logic                         reset,
    idct_zigzag_block_feeder_if.slave    s,
    idct_zigzag_block_feeder_if.master   m
);

    // Builds the zig-zag index -> natural position table by walking the
    // anti-diagonals; even diagonals run upward, odd ones downward.
    function automatic logic [63:0][5:0] build_zz();
        logic [63:0][5:0] t;
        int k;
        int r;
        int lo;
        int hi;
        t = '0;
        k = 0;
        for (int d = 0; d < 15; d++) begin
            lo = (d > 7) ? (d - 7) : 0;
            hi = (d < 7) ? d : 7;
            if ((d % 2) == 0) begin
                for (r = hi; r >= lo; r--) begin
                    t[k] = 6'(r * 8 + (d - r));
                    k++;
                end
            end else begin
                for (r = lo; r <= hi; r++) begin
                    t[k] = 6'(r * 8 + (d - r));
                    k++;
                end
            end
        end
        return t;
    endfunction

    localparam logic [63:0][5:0] ZZ = build_zz();

    logic [WIN-1:0]     mem_r [0:1][0:63];
    logic [1:0][63:0]   mask_r;
    logic [1:0]         full_r;
    logic               wr_bank_r;
    logic               rd_bank_r;
    logic [5:0]         index_r;
    logic [2:0]         row_r;
    logic               alive_r;

    logic               accept_s;
    logic               eob_s;
    logic               pop_s;
    logic               drain_end_s;
    logic [8*WIN-1:0]   row_data_s;

    // Ready comes only from registers; alive_r keeps it low until the first
    // edge after reset release.
    assign s.tready    = alive_r & ~full_r[wr_bank_r];
    assign accept_s    = s.tvalid & s.tready;
    assign eob_s       = s.tlast | (index_r == 6'd63);

    assign m.tvalid    = full_r[rd_bank_r];
    assign m.tlast     = full_r[rd_bank_r] & (row_r == 3'd7);
    assign m.tdata     = row_data_s;
    assign pop_s       = m.tvalid & m.tready;
    assign drain_end_s = pop_s & (row_r == 3'd7);

    // Row assembly: unsent positions (mask clear) read as zero, and the bus
    // is held at zero whenever no row is being offered.
    always_comb begin
        row_data_s = '0;
        for (int j = 0; j < 8; j++) begin
            if (full_r[rd_bank_r] && mask_r[rd_bank_r][{row_r, 3'(j)}]) begin
                row_data_s[j*WIN +: WIN] = mem_r[rd_bank_r][{row_r, 3'(j)}];
            end else begin
                row_data_s[j*WIN +: WIN] = '0;
            end
        end
    end

    // Coefficient storage; validity is tracked by the masks, so no reset.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            mem_r[wr_bank_r][ZZ[index_r]] <= s.tdata;
        end
    end

    // Control state: fill pointer, drain pointer, bank status and masks.
    // A fill write and a drain release can never hit the same bank in one
    // cycle: writing needs full clear, releasing needs full set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_r    <= '0;
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            index_r   <= 6'd0;
            row_r     <= 3'd0;
            alive_r   <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (accept_s) begin
                mask_r[wr_bank_r][ZZ[index_r]] <= 1'b1;
                if (eob_s) begin
                    full_r[wr_bank_r] <= 1'b1;
                    wr_bank_r         <= ~wr_bank_r;
                    index_r           <= 6'd0;
                end else begin
                    index_r <= index_r + 6'd1;
                end
            end
            if (drain_end_s) begin
                mask_r[rd_bank_r] <= 64'd0;
                full_r[rd_bank_r] <= 1'b0;
                rd_bank_r         <= ~rd_bank_r;
                row_r             <= 3'd0;
            end else if (pop_s) begin
                row_r <= row_r + 3'd1;
            end
        end
    end

endmodule
